// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg: opcode and mode encodings shared by the accumulator CPU.
package acc_cpu_pkg;
    typedef enum logic [3:0] {
        OP_LOAD, OP_STORE, OP_ADD, OP_MUL, OP_SUB, OP_SHL, OP_SHR, OP_JMPX,
        OP_AND, OP_OR, OP_XOR, OP_CMPEQ, OP_JZ, OP_JC, OP_NOT, OP_HALT
    } op_t;
    typedef enum logic [1:0] {
        MODE_LOADPROG, MODE_LOADDATA, MODE_SETPC, MODE_RUN
    } mode_t;
endpackage

// File: rtl/acc_cpu_alu.sv
// acc_cpu_alu: combinational datapath producing the next accumulator and carry.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  op_t               op_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] acc_o,
    output logic              acc_we_o,
    output logic              c_we_o,
    output logic              c_o
);
    localparam int KW = $clog2(DATA_W);
    logic [KW-1:0]       k;
    logic [DATA_W:0]     sum, diff, shl, shr;
    logic [2*DATA_W-1:0] prod;
    assign k    = (d_i > DATA_W'(DATA_W - 1)) ? KW'(DATA_W - 1) : d_i[KW-1:0];
    assign sum  = {1'b0, acc_i} + {1'b0, d_i};
    assign diff = {1'b0, acc_i} - {1'b0, d_i};
    // The extra bit catches the last bit shifted out, which is the carry.
    assign shl  = {1'b0, acc_i} << k;
    assign shr  = {acc_i, 1'b0} >> k;
    assign prod = {{DATA_W{1'b0}}, acc_i} * {{DATA_W{1'b0}}, d_i};
    always_comb begin
        acc_o    = acc_i;
        acc_we_o = 1'b1;
        c_we_o   = 1'b0;
        c_o      = 1'b0;
        case (op_i)
            OP_LOAD:  acc_o = d_i;
            OP_ADD:   {c_we_o, c_o, acc_o} = {1'b1, sum};
            OP_MUL:   {c_we_o, c_o, acc_o} = {1'b1, |prod[2*DATA_W-1:DATA_W], prod[DATA_W-1:0]};
            OP_SUB:   {c_we_o, c_o, acc_o} = {1'b1, diff};
            OP_SHL:   {c_we_o, c_o, acc_o} = {1'b1, shl};
            OP_SHR:   {c_we_o, acc_o, c_o} = {1'b1, shr};
            OP_AND:   acc_o = acc_i & d_i;
            OP_OR:    acc_o = acc_i | d_i;
            OP_XOR:   acc_o = acc_i ^ d_i;
            OP_CMPEQ: acc_o = DATA_W'(acc_i == d_i);
            OP_NOT:   acc_o = ~acc_i;
            default:  acc_we_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/acc_cpu_param.sv
// acc_cpu_param: parametrised accumulator CPU with serially loaded program/data files.
module acc_cpu_param
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] din,
    input  logic              ext_cond,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [3:0]        prog_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] acc_q, acc_d, alu_acc, d, wr_data;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, tgt, wr_addr;
    logic z_q, z_d, c_q, c_d, halted_q, halted_d, cond_q;
    logic prog_we, data_we, acc_we, c_we, alu_c, taken;
    op_t  op;
    assign op     = op_t'(prog_q[pc_q]);
    assign d      = data_q[pc_q];
    assign tgt    = d[ADDR_W-1:0];
    assign pc_inc = pc_q + 1'b1;
    assign taken  = (op == OP_JMPX && cond_q) || (op == OP_JZ && z_q) || (op == OP_JC && c_q);
    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i    (op),
        .acc_i   (acc_q),
        .d_i     (d),
        .acc_o   (alu_acc),
        .acc_we_o(acc_we),
        .c_we_o  (c_we),
        .c_o     (alu_c)
    );
    always_comb begin
        pc_d     = pc_q;
        acc_d    = acc_q;
        z_d      = z_q;
        c_d      = c_q;
        halted_d = halted_q;
        prog_we  = 1'b0;
        data_we  = 1'b0;
        wr_addr  = pc_q;
        wr_data  = din;
        case (mode_t'(mode))
            MODE_LOADPROG: {prog_we, pc_d, halted_d} = {1'b1, pc_inc, 1'b0};
            MODE_LOADDATA: {data_we, pc_d, halted_d} = {1'b1, pc_inc, 1'b0};
            MODE_SETPC:    {pc_d, halted_d} = {din[ADDR_W-1:0], 1'b0};
            MODE_RUN: if (!halted_q) begin
                pc_d     = op == OP_HALT ? pc_q : taken ? tgt : pc_inc;
                acc_d    = acc_we ? alu_acc : acc_q;
                z_d      = acc_we ? (alu_acc == '0) : z_q;
                c_d      = c_we ? alu_c : c_q;
                halted_d = op == OP_HALT;
                data_we  = op == OP_STORE;
                wr_addr  = tgt;
                wr_data  = acc_q;
            end
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q     <= '0;
            acc_q    <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            halted_q <= 1'b0;
            cond_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                prog_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            z_q      <= z_d;
            c_q      <= c_d;
            halted_q <= halted_d;
            cond_q   <= ext_cond;
            if (prog_we) prog_q[wr_addr] <= din[3:0];
            if (data_we) data_q[wr_addr] <= wr_data;
        end
    end
    assign acc    = acc_q;
    assign pc     = pc_q;
    assign flag_z = z_q;
    assign flag_c = c_q;
    assign halted = halted_q;
endmodule

// File: doc/acc_cpu_param.md
# acc_cpu_param

Parametrised next-generation accumulator CPU for the 8-pin tile family. It stores a program (4-bit opcodes) and data words in on-chip register files, both loaded serially through a mode port, then executes one instruction per clock. Relative to the fixed 4-bit machine, it adds width and depth parameters, zero and carry flags, flag-conditional jumps, XOR, and a HALT state. A thin pin wrapper maps it onto the 8-bit tile I/O.

## Interface
Parameters:
- DATA_W, 4: accumulator/data word width. Constraint: DATA_W ≥ 4 and DATA_W ≥ ADDR_W.
- ADDR_W, 4: pc/address width. DEPTH = 2**ADDR_W words in each of prog and data.

Ports:
- clock  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-low.
- mode  in  2  0 LOADPROG, 1 LOADDATA, 2 SETPC, 3 RUN.
- din  in  DATA_W  load/setpc data.
- ext_cond  in  1  external jump condition, registered internally.
- acc  out  DATA_W  accumulator.
- pc  out  ADDR_W  program counter.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.
- halted  out  1  HALT executed, execution frozen.

## Operation
- Reset (reset==0 at edge): pc=0, acc=0, flag_z=0, flag_c=0, halted=0, cond_q=0, every prog and data word = 0. Reset overrides mode.
- cond_q <= ext_cond every non-reset cycle.
- LOADPROG: prog[pc] <= din[3:0]; pc <= pc+1; halted <= 0.
- LOADDATA: data[pc] <= din; pc <= pc+1; halted <= 0.
- SETPC: pc <= din[ADDR_W-1:0]; halted <= 0.
- RUN, halted=1: no state change except cond_q.
- RUN, halted=0: execute op = prog[pc], d = data[pc], tgt = d[ADDR_W-1:0]; pc <= pc+1 unless noted.
  - 0 LOAD: acc=d.
  - 1 STORE: data[tgt] <= acc.
  - 2 ADD: {C,acc}=acc+d.
  - 3 MUL: acc=low DATA_W bits of acc*d; C=1 iff the high half is nonzero.
  - 4 SUB: acc=acc-d; C=borrow (acc<d).
  - 5 SHL: k=min(d, DATA_W-1); acc<<=k; C=bit DATA_W-k of the old acc (0 if k=0).
  - 6 SHR: same k; acc>>=k (logical); C=bit k-1 of the old acc (0 if k=0).
  - 7 JMPX: pc = cond_q ? tgt : pc+1.
  - 8 AND, 9 OR, 10 XOR: bitwise with d.
  - 11 CMPEQ: acc = (acc==d) zero-extended.
  - 12 JZ: pc = flag_z ? tgt : pc+1.
  - 13 JC: pc = flag_c ? tgt : pc+1.
  - 14 NOT: acc=~acc.
  - 15 HALT: halted <= 1; pc unchanged.
- Flags:
  - Every op that writes acc (0, 2–6, 8–11, 14) sets Z to (new acc==0).
  - C is written only by ops 2–6; all other ops preserve C.
  - Jumps, STORE and HALT preserve both flags.
- Arithmetic is unsigned modulo 2**DATA_W. pc increments modulo DEPTH; 15→0 wraps with no side effect.

## Timing
- Single-cycle execution; all outputs are registered and update on the edge that executes the op.
- Memory reads are combinational from the current pc.
- A STORE write becomes visible to reads on the next cycle, including STORE to tgt==pc.
- ext_cond → JMPX latency: ext_cond must be high at the edge before the JMPX cycle. A change coincident with the JMPX edge is not seen.
- JZ/JC use the flags as they stand before the edge, i.e. the results of the previous op.
- Mode changes take effect on the next edge. There is no handshake; mode is sampled every cycle.
- Reset asserted mid-RUN or mid-load clears everything on that edge; no partial writes complete.

## Structure
- Package acc_cpu_pkg: opcode enum op_t (4-bit, values above) and mode enum mode_t.
- Sub-module acc_cpu_alu, combinational: inputs op, acc, d; outputs new acc, acc write-enable, C write-enable, C value. The top holds registers, memories, pc logic and flags.

## Test plan
(DATA_W=8, ADDR_W=4 unless noted)
1. Reset: hold reset=0 for 2 cycles in RUN → acc=0, pc=0, Z=C=halted=0. Release in RUN with empty memories → pc counts 0..15 then wraps to 0; Z=1 after the first cycle.
2. ADD carry + HALT: prog LOAD,ADD,HALT with data 0xF0,0x20, SETPC 0, RUN → acc=0x10, C=1, Z=0 after 2 cycles. Then halted=1 with pc=2 held for 5 further cycles; SETPC 0 clears halted.
3. SUB/JZ: LOAD 5, SUB 5, JZ with tgt 9 → acc=0, Z=1, C=0, pc=9. Repeat with SUB 6 → acc=0xFF, C=1, pc=3.
4. Shifts: acc=0x81, SHL d=1 → 0x02, C=1. acc=0x81, SHL d=9 → clamped to 7 → 0x80, C=0. acc=0x81, SHR d=1 → 0x40, C=1.
5. JMPX: ext_cond=1 on the cycle before JMPX tgt=0xC → pc=0xC. ext_cond=1 only on the JMPX edge → pc=pc+1.
6. STORE then LOAD: acc=0x5A, STORE tgt=7, then execute LOAD at pc=7 → acc=0x5A. Assert reset mid-RUN → all memories read 0 afterwards.
